md_sched: RTL and testbench

- Sequencer for the multi-cycle multiply/divide unit and the HI/LO registers of the pipelined MIPS core.
- Consumes the E-stage HI/LO opcode from the control unit (mult/multu/div/divu/mfhi/mflo/mthi/mtlo). Runs the fixed-latency busy countdown and commits results to HI/LO.
- Drives the D-stage stall for md/mt/mf instructions while the unit is busy.
- Suppresses E-stage operations cancelled by an exception or interrupt.

---
 rtl/md_sched_pkg.sv | 15 +
 rtl/md_compute.sv | 34 +++
 rtl/md_sched.sv | 85 ++++++++
 tb/tb_md_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// md_sched_pkg: HI/LO opcode encodings shared with the control unit.
package md_sched_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } hilo_op_e;
  typedef enum logic {IDLE, RUN} md_state_e;
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational 64-bit mult/div result generator.
module md_compute
  import md_sched_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero_o
);
  logic [63:0] sprod, uprod;
  logic signed [63:0] sa, sb, sq, sr;
  logic [31:0] dv, uq, ur;
  always_comb begin
    dv = (rt_i == '0) ? 32'd1 : rt_i;
    sprod = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    uprod = {32'd0, rs_i} * {32'd0, rt_i};
    // 64-bit signed divide makes 0x80000000 / -1 land on 0x80000000 rem 0
    sa = {{32{rs_i[31]}}, rs_i};
    sb = {{32{dv[31]}}, dv};
    sq = sa / sb;
    sr = sa % sb;
    uq = rs_i / dv;
    ur = rs_i % dv;
    hi_o = (op_i == OP_MULT)  ? sprod[63:32] :
           (op_i == OP_MULTU) ? uprod[63:32] :
           (op_i == OP_DIV)   ? sr[31:0] : ur;
    lo_o = (op_i == OP_MULT)  ? sprod[31:0] :
           (op_i == OP_MULTU) ? uprod[31:0] :
           (op_i == OP_DIV)   ? sq[31:0] : uq;
    div_by_zero_o = (op_i == OP_DIV || op_i == OP_DIVU) && rt_i == '0;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer with HI/LO registers and D-stage stall.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_HILOOp,
  input  logic [31:0] E_rsData,
  input  logic [31:0] E_rtData,
  input  logic        E_cancel,
  input  logic        D_mdUse,
  output logic        start,
  output logic        busy,
  output logic        D_stallMD,
  output logic [31:0] E_hiloRead,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic pend_dz_q, pend_dz_d;
  logic [31:0] c_hi, c_lo;
  logic c_dz, is_mul, is_md, mt_ok;
  md_compute u_compute (
    .op_i(E_HILOOp), .rs_i(E_rsData), .rt_i(E_rtData),
    .hi_o(c_hi), .lo_o(c_lo), .div_by_zero_o(c_dz)
  );
  assign busy = state_q == RUN;
  assign is_mul = E_HILOOp == OP_MULT || E_HILOOp == OP_MULTU;
  assign is_md = is_mul || E_HILOOp == OP_DIV || E_HILOOp == OP_DIVU;
  assign start = is_md && !E_cancel && !busy;
  assign mt_ok = !E_cancel && !busy;
  assign D_stallMD = D_mdUse && (start || busy);
  assign E_hiloRead = (E_HILOOp == OP_MFHI) ? hi_q : (E_HILOOp == OP_MFLO) ? lo_q : '0;
  assign HI = hi_q;
  assign LO = lo_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d = (mt_ok && E_HILOOp == OP_MTHI) ? E_rsData : hi_q;
    lo_d = (mt_ok && E_HILOOp == OP_MTLO) ? E_rsData : lo_q;
    if (start) begin
      state_d = RUN;
      cnt_d = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      pend_hi_d = c_hi;
      pend_lo_d = c_lo;
      pend_dz_d = c_dz;
    end
    if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        hi_d = pend_dz_q ? hi_q : pend_hi_q;
        lo_d = pend_dz_q ? lo_q : pend_lo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched.
module tb_md_sched;
  logic clk = 1'b0, reset = 1'b1, E_cancel = 1'b0, D_mdUse = 1'b0;
  logic [3:0] E_HILOOp = 4'd0;
  logic [31:0] E_rsData = '0, E_rtData = '0;
  logic start, busy, D_stallMD;
  logic [31:0] E_hiloRead, HI, LO;
  int checks = 0, errors = 0;
  md_sched dut (
    .clk(clk), .reset(reset), .E_HILOOp(E_HILOOp), .E_rsData(E_rsData),
    .E_rtData(E_rtData), .E_cancel(E_cancel), .D_mdUse(D_mdUse),
    .start(start), .busy(busy), .D_stallMD(D_stallMD),
    .E_hiloRead(E_hiloRead), .HI(HI), .LO(LO)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    E_HILOOp = op;
    E_rsData = rs;
    E_rtData = rt;
    #1;
  endtask
  task automatic run_busy(input string tag, input int n, input logic stall);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_stall"}, {31'd0, D_stallMD}, {31'd0, stall});
      tick;
    end
    check({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    check("mult_start", {31'd0, start}, 32'd1);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    check("mult_start_once", {31'd0, start}, 32'd0);
    check("mult_hi_mid", HI, 32'h0);
    run_busy("mult", 5, 1'b0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);
    D_mdUse = 1'b1;
    issue(4'd2, 32'hFFFFFFFF, 32'd2);
    check("multu_stall_start", {31'd0, D_stallMD}, 32'd1);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    run_busy("multu", 5, 1'b1);
    check("multu_stall_end", {31'd0, D_stallMD}, 32'd0);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);
    D_mdUse = 1'b0;
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    run_busy("div", 10, 1'b0);
    check("div_hi", HI, 32'hFFFFFFFF);
    check("div_lo", LO, 32'hFFFFFFFD);
    issue(4'd4, 32'd9, 32'd0);
    check("divu0_start", {31'd0, start}, 32'd1);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    run_busy("divu0", 10, 1'b0);
    check("divu0_hi", HI, 32'hFFFFFFFF);
    check("divu0_lo", LO, 32'hFFFFFFFD);
    issue(4'd7, 32'h12345678, 32'd0);
    tick;
    check("mthi_hi", HI, 32'h12345678);
    issue(4'd6, 32'd0, 32'd0);
    check("mflo_read", E_hiloRead, 32'hFFFFFFFD);
    issue(4'd5, 32'd0, 32'd0);
    check("mfhi_read", E_hiloRead, 32'h12345678);
    issue(4'd0, 32'd0, 32'd0);
    check("none_read", E_hiloRead, 32'h0);
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    tick;
    issue(4'd7, 32'hDEADBEEF, 32'd0);
    check("mt_busy_start", {31'd0, start}, 32'd0);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    check("mt_busy_ignored", HI, 32'h12345678);
    run_busy("ovf", 9, 1'b0);
    check("ovf_hi", HI, 32'h0);
    check("ovf_lo", LO, 32'h80000000);
    E_cancel = 1'b1;
    issue(4'd1, 32'd3, 32'd3);
    check("cancel_start", {31'd0, start}, 32'd0);
    tick;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    issue(4'd8, 32'h11111111, 32'd0);
    tick;
    check("cancel_mtlo", LO, 32'h80000000);
    E_cancel = 1'b0;
    issue(4'd7, 32'hA5A5A5A5, 32'd0);
    tick;
    issue(4'd8, 32'h5A5A5A5A, 32'd0);
    tick;
    check("mthi2", HI, 32'hA5A5A5A5);
    check("mtlo2", LO, 32'h5A5A5A5A);
    issue(4'd3, 32'd100, 32'd7);
    tick;
    issue(4'd0, 32'd0, 32'd0);
    tick;
    tick;
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick;
    check("rst2_busy", {31'd0, busy}, 32'd0);
    check("rst2_hi", HI, 32'h0);
    check("rst2_lo", LO, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick;
    check("late_busy", {31'd0, busy}, 32'd0);
    check("late_hi", HI, 32'h0);
    check("late_lo", LO, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
